// File: rtl/lerp_if.sv
// -----------------------------------------------------------------------------
// lerp_if -- sample/ratio bus of the pipelined linear interpolator.
//   master : drives in_valid, ina, inb, ratio; receives out, out_valid
//   slave  : the interpolator; consumes inputs, drives out, out_valid
// Ports carried:
//   in_valid  1                inputs valid this cycle
//   ina       INPUT_BITS       signed sample A (ratio = 0 endpoint)
//   inb       INPUT_BITS       signed sample B (ratio -> 1 endpoint)
//   ratio     RATIO_FRAC_BITS  unsigned weight of inb, value ratio/2**F
//   out       INPUT_BITS       signed interpolated sample
//   out_valid 1                out holds the result of an accepted input
// -----------------------------------------------------------------------------
interface lerp_if #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
);
  logic                        in_valid;
  logic [INPUT_BITS-1:0]       ina;
  logic [INPUT_BITS-1:0]       inb;
  logic [RATIO_FRAC_BITS-1:0]  ratio;
  logic [INPUT_BITS-1:0]       out;
  logic                        out_valid;

  modport master (
    output in_valid, ina, inb, ratio,
    input  out, out_valid
  );

  modport slave (
    input  in_valid, ina, inb, ratio,
    output out, out_valid
  );
endinterface

// File: rtl/lerp.sv
// -----------------------------------------------------------------------------
// lerp -- two-stage pipelined linear interpolator for wavetable oscillators.
//   out = ina + floor((inb - ina) * ratio / 2**RATIO_FRAC_BITS)
// One input accepted per clock, no stalls, latency two clocks.
// Ports:
//   clock  in   1   all state updates on posedge
//   reset  in   1   asynchronous, active-high; clears every pipeline register
//   bus    slave    in_valid/ina/inb/ratio in, out/out_valid out (registered)
// -----------------------------------------------------------------------------
module lerp #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
) (
  input  logic    clock,
  input  logic    reset,
  lerp_if.slave   bus
);
  // Difference needs one extra bit so inb - ina never overflows.
  localparam int DW = INPUT_BITS + 1;
  // Ratio carries a zero sign bit so it can join a signed product.
  localparam int RW = RATIO_FRAC_BITS + 1;
  // Full product width of a DW x RW signed multiply.
  localparam int PW = INPUT_BITS + RATIO_FRAC_BITS + 2;

  // Stage 1 registers
  logic [INPUT_BITS-1:0] r_ina;
  logic [DW-1:0]         r_diff;
  logic [RW-1:0]         r_ratio;
  logic                  r_v1;
  // Stage 2 registers
  logic [INPUT_BITS-1:0] r_out;
  logic                  r_v2;

  logic [DW-1:0] w_diff;
  logic [PW-1:0] w_diff_x;
  logic [PW-1:0] w_ratio_x;
  logic [PW-1:0] w_prod;
  logic [DW-1:0] w_step;
  logic [DW-1:0] w_sum;
  logic          w_unused;

  // Sign-extend both samples before subtracting so the difference is exact.
  assign w_diff = {bus.inb[INPUT_BITS-1], bus.inb} - {bus.ina[INPUT_BITS-1], bus.ina};

  // Operands widened to the product width; the modular product of the
  // two's-complement encodings equals the true signed product, which fits.
  assign w_diff_x  = {{(PW-DW){r_diff[DW-1]}}, r_diff};
  assign w_ratio_x = {{(PW-RW){1'b0}}, r_ratio};
  assign w_prod    = w_diff_x * w_ratio_x;

  // Taking bits above the fraction is an arithmetic shift right, i.e. floor
  // rounding. |prod >>> F| <= |diff|, so DW bits hold it without loss.
  assign w_step = w_prod[RATIO_FRAC_BITS +: DW];

  // Result lies between ina and inb, so the top bit of the DW-bit sum is a
  // pure sign copy and dropping it is lossless.
  assign w_sum = {r_ina[INPUT_BITS-1], r_ina} + w_step;

  // Bits that are mathematically redundant by construction.
  assign w_unused = ^{w_prod[PW-1], w_prod[RATIO_FRAC_BITS-1:0], w_sum[DW-1]};

  // Stage 1: capture ina, the exact difference, zero-extended ratio and valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ina   <= '0;
      r_diff  <= '0;
      r_ratio <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_ina   <= bus.ina;
      r_diff  <= w_diff;
      r_ratio <= {1'b0, bus.ratio};
      r_v1    <= bus.in_valid;
    end
  end

  // Stage 2: register the interpolated sample and the delayed valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_out <= w_sum[INPUT_BITS-1:0];
      r_v2  <= r_v1;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_v2;
endmodule

// File: tb/tb_lerp.sv
// -----------------------------------------------------------------------------
// tb_lerp -- self-checking bench for lerp (INPUT_BITS=16, RATIO_FRAC_BITS=8).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge and compared with the value expected for the input presented two
// cycles earlier.
// -----------------------------------------------------------------------------
module tb_lerp;
  logic clock = 1'b0;
  logic reset;

  lerp_if #(.INPUT_BITS(16), .RATIO_FRAC_BITS(8)) bus ();

  lerp #(.INPUT_BITS(16), .RATIO_FRAC_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectation for the slot presented one (e1) and two (e2) cycles ago.
  logic        e1_v, e2_v;
  logic [15:0] e1_o, e2_o;
  string       e1_t, e2_t;

  // Reference: a + floor((b - a) * r / 256), floor done by explicit correction
  // of C-style truncating division.
  function automatic int lerp_ref(input int a, input int b, input int r);
    int p;
    int q;
    p = (b - a) * r;
    q = p / 256;
    if ((p < 0) && ((p % 256) != 0)) q = q - 1;
    return a + q;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d (%h) expected=%0d (%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input int a, input int b,
                      input int r, input int e);
    logic [15:0] ev;
    @(negedge clock);
    chk({e2_t, ".valid"}, {15'd0, bus.out_valid}, {15'd0, e2_v});
    if (e2_v) chk({e2_t, ".out"}, bus.out, e2_o);
    ev = e[15:0];
    bus.in_valid = v;
    bus.ina      = a[15:0];
    bus.inb      = b[15:0];
    bus.ratio    = r[7:0];
    e2_v = e1_v; e2_o = e1_o; e2_t = e1_t;
    e1_v = v;    e1_o = ev;   e1_t = tag;
  endtask

  task automatic rand_step(input string tag, input logic v);
    int a, b, r, k;
    a = int'($urandom_range(0, 65535)) - 32768;
    b = int'($urandom_range(0, 65535)) - 32768;
    r = int'($urandom_range(0, 255));
    k = int'($urandom_range(0, 7));
    if (k == 0) r = 0;
    if (k == 1) r = 255;
    if (k == 2) b = a;
    step(tag, v, a, b, r, lerp_ref(a, b, r));
  endtask

  initial begin
    e1_v = 1'b0; e2_v = 1'b0; e1_o = 16'd0; e2_o = 16'd0;
    e1_t = "idle"; e2_t = "idle";
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.ina = 16'd0; bus.inb = 16'd0; bus.ratio = 8'd0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst.out", bus.out, 16'd0);
    chk("rst.valid", {15'd0, bus.out_valid}, 16'd0);
    reset = 1'b0;

    // Directed points, separated by idle slots so latency is exact.
    step("mid",       1'b1,      0,    256, 128,    128);
    step("gap",       1'b0,      0,      0,   0,      0);
    step("gap",       1'b0,      0,      0,   0,      0);
    step("r0",        1'b1,  -1000,   1000,   0,  -1000);
    step("rmax",      1'b1,  -1000,   1000, 255,    992);
    step("neg",       1'b1,    100,   -100,  64,     50);
    step("floor",     1'b1,      0,     -1, 128,     -1);
    step("fullup",    1'b1, -32768,  32767, 255,  32511);
    // floor(-65535*255/256) = -65280, so 32767 - 65280
    step("fulldown",  1'b1,  32767, -32768, 255, -32513);
    step("eq",        1'b1,  -1234,  -1234, 200,  -1234);
    step("gap",       1'b0,      0,      0,   0,      0);

    // Eight back-to-back random vectors, then a gap.
    for (int i = 0; i < 8; i++) rand_step("burst", 1'b1);
    for (int i = 0; i < 3; i++) rand_step("gap", 1'b0);

    // Random stream with random valid pattern.
    for (int i = 0; i < 40; i++) rand_step("rnd", 1'($urandom_range(0, 1)));

    // Asynchronous reset with two samples in flight.
    step("inflA", 1'b1, 10, 20, 128, 15);
    step("inflB", 1'b1, 30, 40, 128, 35);
    @(posedge clock);
    #2;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst.out", bus.out, 16'd0);
    chk("arst.valid", {15'd0, bus.out_valid}, 16'd0);
    e1_v = 1'b0; e2_v = 1'b0; e1_t = "post_rst"; e2_t = "post_rst";
    @(negedge clock);
    reset = 1'b0;

    // After release: idle slots must show no stale output, then resume.
    for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) rand_step("resume", 1'b1);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
